// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous level and emits one-cycle edge pulses.
// A change is accepted only after STABLE_CYCLES consecutive equal synchronised samples.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic d_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_d_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // busy is registered alongside the state so it never glitches on a decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_d_clean <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= IDLE_HIGH;
            r_cnt     <= '0;
            r_d_clean <= 1'b1;
            r_rise    <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_d_clean <= 1'b0;
            r_fall    <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= IDLE_LOW;
          r_cnt     <= '0;
          r_d_clean <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign d_clean    = r_d_clean;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=4), including a
// negedge D flip-flop consumer fed by d_clean.
module tb_debounce_sync;

  logic clk;
  logic rst_n;
  logic raw_in;
  logic d_clean;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
  logic q;

  int total;
  int passed;

  typedef struct {
    logic rst_n;
    logic raw;
    logic d;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  debounce_sync #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .d_clean   (d_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  // Downstream negedge D flip-flop consumer.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d_clean;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic r, input logic w, input logic d, input logic ri,
                     input logic fa, input logic b);
    vec_t v;
    v.rst_n = r; v.raw = w; v.d = d; v.rise = ri; v.fall = fa; v.busy = b;
    vecs.push_back(v);
  endtask

  // raw steps to 1 before posedge 1 from a settled low: accepted at posedge 6.
  task automatic add_rise();
    add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 1, 0, 0); add(1, 1, 1, 0, 0, 0); add(1, 1, 1, 0, 0, 0);
  endtask

  task automatic add_fall();
    add(1, 0, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0); add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    raw_in = 1'b1;

    // Reset held with raw high, then released with raw still high.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0);
    add_rise();
    add_fall();
    add_rise();
    add_fall();
    // Bounce: 3 stable samples then a low sample is rejected; a 4-sample run is accepted.
    add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 1, 0, 0); add(1, 1, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n  = vecs[i].rst_n;
      raw_in = vecs[i].raw;
      tick();
      chk("d_clean", i, d_clean, vecs[i].d);
      chk("rise_pulse", i, rise_pulse, vecs[i].rise);
      chk("fall_pulse", i, fall_pulse, vecs[i].fall);
      chk("busy", i, busy, vecs[i].busy);
      @(negedge clk);
      #1;
      chk("consumer_q", i, q, vecs[i].d);
    end

    // Reset asserted mid-qualification of a pending fall.
    raw_in = 1'b0;
    tick();
    tick();
    tick();
    chk("busy_before_reset", 0, busy, 1'b1);
    chk("d_before_reset", 0, d_clean, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d", 0, d_clean, 1'b0);
    chk("async_rst_busy", 0, busy, 1'b0);
    chk("async_rst_rise", 0, rise_pulse, 1'b0);
    chk("async_rst_fall", 0, fall_pulse, 1'b0);
    chk("async_rst_q", 0, q, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post_rst_d", k, d_clean, 1'b0);
      chk("post_rst_busy", k, busy, 1'b0);
      chk("post_rst_rise", k, rise_pulse, 1'b0);
      chk("post_rst_fall", k, fall_pulse, 1'b0);
      @(negedge clk);
      #1;
      chk("post_rst_q", k, q, 1'b0);
    end

    // Lone 1-cycle glitch never reaches qualification.
    raw_in = 1'b1;
    tick();
    raw_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("glitch_d", k, d_clean, 1'b0);
      chk("glitch_rise", k, rise_pulse, 1'b0);
      chk("glitch_busy", k, busy, (k == 2) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
